clock_display_scan: RTL and testbench

Display back-end for the digital clock. It sits directly downstream of the seconds/minutes/hours counter chain and consumes its binary time outputs. It converts each field to two BCD digits with a sequential repeated-subtraction divider and latches all six digits atomically into a display buffer. It then time-multiplexes the buffer onto a six-digit common-cathode 7-segment display.

---
 rtl/clock_display_scan.sv | 178 +++++++++++++++++
 tb/tb_clock_display_scan.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_scan.sv
// Binary clock time to BCD via repeated subtraction, latched atomically into a display buffer
// and scanned onto a six-digit 7-segment display. Define CLOCK_DISPLAY_BLANK_EN to blank hours-tens 0.
module clock_display_scan #(
  parameter int unsigned SCAN_DIV = 50_000
) (
  input  logic       i_sysclk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic [5:0] i_seconds,
  input  logic [5:0] i_minutes,
  input  logic [4:0] i_hours,
  output logic [6:0] o_segments,
  output logic [5:0] o_digit_sel,
  output logic       o_busy
);

  localparam int unsigned PrescW = 20;
  localparam logic [PrescW-1:0] TermCnt = PrescW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {StIdle, StCapture, StDiv, StCommit} state_e;

  state_e            state_q, state_d;
  logic              force_conv_q, force_conv_d;
  logic [16:0]       snap_q, snap_d;
  logic [1:0]        field_q, field_d;
  logic [5:0]        work_q, work_d;
  logic [2:0]        tens_q, tens_d;
  logic [5:0][3:0]   pend_q, pend_d;
  logic [5:0][3:0]   disp_q, disp_d;
  logic              busy_q, busy_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [2:0]        idx_q, idx_d;
  logic              resume_q, resume_d;
  logic [6:0]        seg_q, seg_d;
  logic [5:0]        sel_q, sel_d;
  logic [16:0]       time_in;

  assign time_in = {i_hours, i_minutes, i_seconds};

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'b0111111;
      4'd1:    seg_decode = 7'b0000110;
      4'd2:    seg_decode = 7'b1011011;
      4'd3:    seg_decode = 7'b1001111;
      4'd4:    seg_decode = 7'b1100110;
      4'd5:    seg_decode = 7'b1101101;
      4'd6:    seg_decode = 7'b1111101;
      4'd7:    seg_decode = 7'b0000111;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1101111;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  // Conversion FSM: snapshot, divide seconds/minutes/hours in turn, then commit all six digits.
  always_comb begin
    state_d      = state_q;
    force_conv_d = force_conv_q;
    snap_d       = snap_q;
    field_d      = field_q;
    work_d       = work_q;
    tens_d       = tens_q;
    pend_d       = pend_q;
    disp_d       = disp_q;
    case (state_q)
      StIdle: begin
        if (force_conv_q || (time_in != snap_q)) begin
          state_d      = StCapture;
          force_conv_d = 1'b0;
        end
      end
      StCapture: begin
        snap_d  = time_in;
        field_d = 2'd0;
        work_d  = i_seconds;
        tens_d  = 3'd0;
        state_d = StDiv;
      end
      StDiv: begin
        if (work_q >= 6'd10) begin
          work_d = work_q - 6'd10;
          tens_d = tens_q + 3'd1;
        end else begin
          pend_d[{field_q, 1'b0}] = work_q[3:0];
          pend_d[{field_q, 1'b1}] = {1'b0, tens_q};
          tens_d = 3'd0;
          case (field_q)
            2'd0: begin
              field_d = 2'd1;
              work_d  = snap_q[11:6];
            end
            2'd1: begin
              field_d = 2'd2;
              work_d  = {1'b0, snap_q[16:12]};
            end
            default: state_d = StCommit;
          endcase
        end
      end
      StCommit: begin
        disp_d  = pend_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Scan: outputs only change on a terminal count, so a buffer update never appears mid-slot.
  // After a disable, the first terminal count redrives the held index instead of advancing.
  always_comb begin
    presc_d  = presc_q;
    idx_d    = idx_q;
    resume_d = resume_q;
    seg_d    = seg_q;
    sel_d    = sel_q;
    if (!i_en) begin
      seg_d    = 7'd0;
      sel_d    = 6'd0;
      resume_d = 1'b1;
    end else if (presc_q == TermCnt) begin
      presc_d = '0;
      if (!resume_q) begin
        idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
      resume_d = 1'b0;
      sel_d    = 6'd1 << idx_d;
      seg_d    = seg_decode(disp_q[idx_d]);
`ifdef CLOCK_DISPLAY_BLANK_EN
      if ((idx_d == 3'd5) && (disp_q[5] == 4'd0)) begin
        seg_d = 7'd0;
      end
`endif
    end else begin
      presc_d = presc_q + PrescW'(1);
    end
  end

  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= StIdle;
      force_conv_q <= 1'b1;
      snap_q       <= '0;
      field_q      <= 2'd0;
      work_q       <= 6'd0;
      tens_q       <= 3'd0;
      pend_q       <= '0;
      disp_q       <= '0;
      busy_q       <= 1'b0;
      presc_q      <= '0;
      idx_q        <= 3'd0;
      resume_q     <= 1'b0;
      seg_q        <= 7'd0;
      sel_q        <= 6'd0;
    end else begin
      state_q      <= state_d;
      force_conv_q <= force_conv_d;
      snap_q       <= snap_d;
      field_q      <= field_d;
      work_q       <= work_d;
      tens_q       <= tens_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      busy_q       <= busy_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      resume_q     <= resume_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
    end
  end

  assign o_segments  = seg_q;
  assign o_digit_sel = sel_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan: directed scenarios plus random time/enable traffic
// compared against a behavioural model (div/mod digits, latency formula, slot rotation).
module tb_clock_display_scan;

  localparam int ScanDiv = 4;
`ifdef CLOCK_DISPLAY_BLANK_EN
  localparam bit BlankEn = 1'b1;
`else
  localparam bit BlankEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [5:0] sec;
  logic [5:0] mn;
  logic [4:0] hr;
  logic [6:0] seg;
  logic [5:0] sel;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;

  clock_display_scan #(
    .SCAN_DIV(ScanDiv)
  ) dut (
    .i_sysclk   (clk),
    .i_reset_n  (rst_n),
    .i_en       (en),
    .i_seconds  (sec),
    .i_minutes  (mn),
    .i_hours    (hr),
    .o_segments (seg),
    .o_digit_sel(sel),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [5:0]  m_sel;
  logic [6:0]  m_seg;
  logic        m_busy;
  logic        m_resume;
  logic        m_force;
  logic [16:0] m_snap;
  int          m_presc;
  int          m_idx;
  int          m_left;
  int          m_buf [6];
  int          m_new [6];

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0:       return 7'b0111111;
      1:       return 7'b0000110;
      2:       return 7'b1011011;
      3:       return 7'b1001111;
      4:       return 7'b1100110;
      5:       return 7'b1101101;
      6:       return 7'b1111101;
      7:       return 7'b0000111;
      8:       return 7'b1111111;
      9:       return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int next_slot(input int idx, input logic resume);
    return resume ? idx : (idx + 1) % 6;
  endfunction

  function automatic logic [6:0] slot_code(input int i);
    if (BlankEn && (i == 5) && (m_buf[5] == 0)) return 7'b0000000;
    return seg_code(m_buf[i]);
  endfunction

  // m_left: 0 idle, -1 capture pending, otherwise cycles left until the commit edge.
  always @(posedge clk or negedge rst_n) begin : ref_model
    if (!rst_n) begin
      m_presc  <= 0;
      m_idx    <= 0;
      m_resume <= 1'b0;
      m_sel    <= '0;
      m_seg    <= '0;
      m_busy   <= 1'b0;
      m_left   <= 0;
      m_force  <= 1'b1;
      m_snap   <= '0;
      m_buf    <= '{default: 0};
      m_new    <= '{default: 0};
    end else begin
      if (!en) begin
        m_sel    <= '0;
        m_seg    <= '0;
        m_resume <= 1'b1;
      end else if (m_presc == ScanDiv - 1) begin
        m_presc  <= 0;
        m_idx    <= next_slot(m_idx, m_resume);
        m_resume <= 1'b0;
        m_sel    <= 6'd1 << next_slot(m_idx, m_resume);
        m_seg    <= slot_code(next_slot(m_idx, m_resume));
      end else begin
        m_presc <= m_presc + 1;
      end
      if (m_left == 0) begin
        if (m_force || ({hr, mn, sec} != m_snap)) begin
          m_force <= 1'b0;
          m_left  <= -1;
          m_busy  <= 1'b1;
        end
      end else if (m_left == -1) begin
        m_snap <= {hr, mn, sec};
        m_new  <= '{int'(sec) % 10, int'(sec) / 10, int'(mn) % 10, int'(mn) / 10,
                    int'(hr) % 10, int'(hr) / 10};
        m_left <= int'(sec) / 10 + int'(mn) / 10 + int'(hr) / 10 + 4;
      end else if (m_left == 1) begin
        m_left <= 0;
        m_buf  <= m_new;
        m_busy <= 1'b0;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    sec = '0;
    mn = '0;
    hr = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({seg, sel, busy} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: seg/sel/busy=%b/%b/%b required all zero", seg, sel, busy);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== (c <= 5)) begin
        n_fail++;
        $display("FAIL reset_busy c=%0d: got %b required %b", c, busy, (c <= 5));
      end
      n_checks++;
      if (sel !== ((c >= 4) ? 6'b000010 : 6'b000000)) begin
        n_fail++;
        $display("FAIL reset_first_sel c=%0d: got %b", c, sel);
      end
      if (c == 4) begin
        n_checks++;
        if (seg !== 7'b0111111) begin
          n_fail++;
          $display("FAIL reset_first_seg: got %b required 0111111", seg);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] obs [6];
    logic       seen5 = 1'b0;
    for (int k = 0; k < 6; k++) obs[k] = 'x;
    en = 1'b1;
    hr = 5'd5;
    mn = 6'd0;
    sec = 6'd0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      n_checks++;
      if ({sel, seg, busy} !== {m_sel, m_seg, m_busy}) begin
        n_fail++;
        $display("FAIL model_leading_zero: sel/seg/busy=%b/%b/%b required %b/%b/%b",
                 sel, seg, busy, m_sel, m_seg, m_busy);
      end
      for (int k = 0; k < 6; k++) if (sel == (6'd1 << k)) obs[k] = seg;
      if (sel[5]) seen5 = 1'b1;
    end
    n_checks++;
    if (obs[5] !== (BlankEn ? 7'b0000000 : 7'b0111111)) begin
      n_fail++;
      $display("FAIL leading_zero_slot5: got %b", obs[5]);
    end
    n_checks++;
    if (obs[4] !== 7'b1101101) begin
      n_fail++;
      $display("FAIL leading_zero_slot4: got %b required 1101101", obs[4]);
    end
    n_checks++;
    if (!seen5) begin
      n_fail++;
      $display("FAIL leading_zero_scan5: got 0 required 1");
    end
  endtask

  task automatic test_full_time();
    logic [6:0] obs [6];
    logic [6:0] want [6] = '{7'b1111111, 7'b1101101, 7'b1101111,
                             7'b1101101, 7'b1001111, 7'b1011011};
    int rise = -1;
    int high = 0;
    for (int k = 0; k < 6; k++) obs[k] = 'x;
    en = 1'b1;
    hr = 5'd23;
    mn = 6'd59;
    sec = 6'd58;
    for (int c = 1; c <= 88; c++) begin
      @(negedge clk);
      n_checks++;
      if ({sel, seg, busy} !== {m_sel, m_seg, m_busy}) begin
        n_fail++;
        $display("FAIL model_full_time: sel/seg/busy=%b/%b/%b required %b/%b/%b",
                 sel, seg, busy, m_sel, m_seg, m_busy);
      end
      if (busy === 1'b1) begin
        if (rise < 0) rise = c;
        high++;
      end
      for (int k = 0; k < 6; k++) if (sel == (6'd1 << k)) obs[k] = seg;
    end
    n_checks++;
    if (rise != 1) begin
      n_fail++;
      $display("FAIL full_time_busy_rise: got cycle %0d required 1", rise);
    end
    n_checks++;
    if (high != 17) begin
      n_fail++;
      $display("FAIL full_time_busy_len: got %0d required 17", high);
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (obs[k] !== want[k]) begin
        n_fail++;
        $display("FAIL full_time_slot%0d: got %b required %b", k, obs[k], want[k]);
      end
    end
  endtask

  task automatic test_enable_gate();
    logic [5:0] prev;
    logic       found = 1'b0;
    logic [5:0] exp_sel;
    en = 1'b1;
    prev = m_sel;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      n_checks++;
      if ({sel, seg, busy} !== {m_sel, m_seg, m_busy}) begin
        n_fail++;
        $display("FAIL model_enable_wait: sel/seg/busy=%b/%b/%b required %b/%b/%b",
                 sel, seg, busy, m_sel, m_seg, m_busy);
      end
      if ((m_sel == 6'b000100) && (prev != 6'b000100)) found = 1'b1;
      prev = m_sel;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL enable_wait_slot2: got timeout required slot 2 within 60 cycles");
    end else begin
      en = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        n_checks++;
        if ({sel, seg} !== 13'd0) begin
          n_fail++;
          $display("FAIL enable_low_blank c=%0d: sel/seg=%b/%b required zero", c, sel, seg);
        end
      end
      en = 1'b1;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        exp_sel = (c < 4) ? 6'b000000 : (c < 8) ? 6'b000100 : (c < 12) ? 6'b001000 : 6'b010000;
        n_checks++;
        if (sel !== exp_sel) begin
          n_fail++;
          $display("FAIL enable_resume c=%0d: got %b required %b", c, sel, exp_sel);
        end
        n_checks++;
        if ({sel, seg, busy} !== {m_sel, m_seg, m_busy}) begin
          n_fail++;
          $display("FAIL model_enable_resume: sel/seg/busy=%b/%b/%b required %b/%b/%b",
                   sel, seg, busy, m_sel, m_seg, m_busy);
        end
      end
    end
  endtask

  task automatic test_reset_mid_div();
    logic [6:0] obs [6];
    int         want [6] = '{6, 5, 4, 3, 2, 1};
    for (int k = 0; k < 6; k++) obs[k] = 'x;
    en = 1'b1;
    hr = 5'd12;
    mn = 6'd34;
    sec = 6'd56;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      n_checks++;
      if ({sel, seg, busy} !== {m_sel, m_seg, m_busy}) begin
        n_fail++;
        $display("FAIL model_mid_div: sel/seg/busy=%b/%b/%b required %b/%b/%b",
                 sel, seg, busy, m_sel, m_seg, m_busy);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({seg, sel, busy} !== 14'd0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: seg/sel/busy=%b/%b/%b required all zero", seg, sel, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      n_checks++;
      if ({sel, seg, busy} !== {m_sel, m_seg, m_busy}) begin
        n_fail++;
        $display("FAIL model_after_reset: sel/seg/busy=%b/%b/%b required %b/%b/%b",
                 sel, seg, busy, m_sel, m_seg, m_busy);
      end
      if (c <= 15) begin
        n_checks++;
        if (busy !== (c <= 14)) begin
          n_fail++;
          $display("FAIL forced_conv_busy c=%0d: got %b required %b", c, busy, (c <= 14));
        end
      end
      if (c == 4) begin
        n_checks++;
        if ({sel, seg} !== {6'b000010, 7'b0111111}) begin
          n_fail++;
          $display("FAIL cleared_buffer: sel/seg=%b/%b required 000010/0111111", sel, seg);
        end
      end
      for (int k = 0; k < 6; k++) if (sel == (6'd1 << k)) obs[k] = seg;
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (obs[k] !== seg_code(want[k])) begin
        n_fail++;
        $display("FAIL forced_conv_slot%0d: got %b required %b", k, obs[k], seg_code(want[k]));
      end
    end
  endtask

  task automatic test_change_during_div();
    logic [6:0] obs [6];
    logic       exp_busy;
    for (int k = 0; k < 6; k++) obs[k] = 'x;
    rst_n = 1'b0;
    en = 1'b1;
    hr = '0;
    mn = '0;
    sec = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      n_checks++;
      if ({sel, seg, busy} !== {m_sel, m_seg, m_busy}) begin
        n_fail++;
        $display("FAIL model_change_div: sel/seg/busy=%b/%b/%b required %b/%b/%b",
                 sel, seg, busy, m_sel, m_seg, m_busy);
      end
      if (c <= 12) begin
        exp_busy = (c <= 5) || ((c >= 7) && (c <= 11));
        n_checks++;
        if (busy !== exp_busy) begin
          n_fail++;
          $display("FAIL change_div_busy c=%0d: got %b required %b", c, busy, exp_busy);
        end
      end
      if (c == 3) sec = 6'd1;
      for (int k = 0; k < 6; k++) if (sel == (6'd1 << k)) obs[k] = seg;
    end
    n_checks++;
    if (obs[0] !== 7'b0000110) begin
      n_fail++;
      $display("FAIL change_div_slot0: got %b required 0000110", obs[0]);
    end
    n_checks++;
    if (obs[1] !== 7'b0111111) begin
      n_fail++;
      $display("FAIL change_div_slot1: got %b required 0111111", obs[1]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        sec = 6'($urandom_range(0, 63));
        mn  = 6'($urandom_range(0, 63));
        hr  = 5'($urandom_range(0, 31));
      end
      en = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(1, 25)) begin
        @(negedge clk);
        n_checks++;
        if ({sel, seg, busy} !== {m_sel, m_seg, m_busy}) begin
          n_fail++;
          $display("FAIL model_random t=%0t: sel/seg/busy=%b/%b/%b required %b/%b/%b",
                   $time, sel, seg, busy, m_sel, m_seg, m_busy);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    en = 1'b1;
    sec = '0;
    mn = '0;
    hr = '0;
    #3;
    test_reset();
    test_leading_zero();
    test_full_time();
    test_enable_gate();
    test_reset_mid_div();
    test_change_during_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
